// File: rtl/uart_msg_sched_if.sv
// Byte stream from the record scheduler to the UART serializer.
// A byte transfers on any rising edge where tx_valid && tx_ready.
interface uart_msg_sched_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_msg_sched.sv
// Round-robin scheduler sharing one UART byte serializer between N_REQ requesters.
// Each grant emits a 4-byte ASCII record (tag, high digit, low digit, CR), then an idle gap.
module uart_msg_sched #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned GAP_CYCLES = 834
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   bcd_in,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 busy,
    uart_msg_sched_if.master     tx
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   sel_q;
    logic [1:0]      idx_q;
    logic [7:0]      snap_q;
    logic [GW-1:0]   gap_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic            busy_q;

    logic            found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;

    function automatic logic [7:0] enc_digit(input logic [3:0] nib);
        return (nib <= 4'd9) ? {4'h3, nib} : 8'h3F;
    endfunction

    // Payload byte for record positions 1..3; position 0 (the tag) is built at grant time.
    function automatic logic [7:0] rec_byte(input logic [1:0] idx, input logic [7:0] snap);
        logic [7:0] b;
        unique case (idx)
            2'd1:    b = enc_digit(snap[7:4]);
            2'd2:    b = enc_digit(snap[3:0]);
            default: b = 8'h0D;
        endcase
        return b;
    endfunction

    // First requesting index at or after the round-robin pointer, with wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PW'((32'(ptr_q) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            sel_q      <= '0;
            idx_q      <= '0;
            snap_q     <= '0;
            gap_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        sel_q      <= pick;
                        snap_q     <= bcd_in[8*pick +: 8];
                        ptr_q      <= PW'((32'(pick) + 1) % N_REQ);
                        idx_q      <= 2'd0;
                        tx_data_q  <= 8'h41 + 8'(pick);
                        tx_valid_q <= 1'b1;
                        gnt_q      <= N_REQ'(1) << pick;
                        busy_q     <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (tx.tx_ready) begin
                        if (idx_q == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            gnt_q      <= '0;
                            done_q     <= N_REQ'(1) << sel_q;
                            if (GAP_CYCLES == 0) begin
                                busy_q  <= 1'b0;
                                state_q <= StIdle;
                            end else begin
                                gap_q   <= GW'(GAP_CYCLES);
                                state_q <= StGap;
                            end
                        end else begin
                            idx_q     <= idx_q + 2'd1;
                            tx_data_q <= rec_byte(idx_q + 2'd1, snap_q);
                        end
                    end
                end
                StGap: begin
                    if (gap_q <= GW'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_uart_msg_sched.sv
// Scoreboard bench for uart_msg_sched: stimulus queues expected bytes/done pulses,
// a negedge monitor pops and compares on every transfer and done pulse.
module tb_uart_msg_sched;

    localparam int unsigned NR  = 4;
    localparam int unsigned GAP = 4;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] gnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [8*NR-1:0] bcd_in;
    logic [NR-1:0] gnt;
    logic [NR-1:0] done;
    logic          busy;

    uart_msg_sched_if tx_if ();

    uart_msg_sched #(
        .N_REQ      (NR),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .bcd_in (bcd_in),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .tx     (tx_if)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   exp_done[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    bit   bp       = 1'b0;

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rst   = 1'b1;
    logic [7:0] prev_data  = 8'h00;
    exp_t       e;
    int         r_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input int r, input logic [7:0] b1, input logic [7:0] b2);
        logic [3:0] oh;
        oh = 4'(1 << r);
        exp_q.push_back('{data: 8'h41 + 8'(r), gnt: oh});
        exp_q.push_back('{data: b1, gnt: oh});
        exp_q.push_back('{data: b2, gnt: oh});
        exp_q.push_back('{data: 8'h0D, gnt: oh});
        exp_done.push_back(r);
    endtask

    task automatic wait_done(input int target, input int limit);
        int n;
        n = 0;
        while (done_cnt < target && n < limit) begin
            if (bp) tx_if.tx_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        tx_if.tx_ready = 1'b1;
        chk("done_timeout", 32'(done_cnt >= target), 32'd1);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Grant one requester for a single record; optionally rewrite its digits after the grant.
    task automatic send_one(input int r, input logic [7:0] v, input logic [7:0] b1,
                            input logic [7:0] b2, input bit change, input logic [7:0] v2);
        int target;
        bcd_in[8*r +: 8] = v;
        req = 4'(1 << r);
        push_rec(r, b1, b2);
        target = done_cnt + 1;
        tick();
        chk("grant_latency_valid", 32'(tx_if.tx_valid), 32'd1);
        chk("grant_latency_tag", 32'(tx_if.tx_data), 32'(8'h41 + 8'(r)));
        req = '0;
        if (change) bcd_in[8*r +: 8] = v2;
        wait_done(target, 400);
    endtask

    always @(negedge clk) begin
        if (!rst && tx_if.tx_valid && tx_if.tx_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", 32'(tx_if.tx_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("tx_data", 32'(tx_if.tx_data), 32'(e.data));
                chk("gnt", 32'(gnt), 32'(e.gnt));
            end
        end
        if (!rst && done !== '0) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                r_pop = exp_done.pop_front();
                chk("done", 32'(done), 32'(1 << r_pop));
            end
            done_cnt <= done_cnt + 1;
        end
        if (!rst && !prev_rst && prev_valid && !prev_ready) begin
            chk("stall_valid", 32'(tx_if.tx_valid), 32'd1);
            chk("stall_data", 32'(tx_if.tx_data), 32'(prev_data));
        end
        prev_valid <= tx_if.tx_valid;
        prev_ready <= tx_if.tx_ready;
        prev_data  <= tx_if.tx_data;
        prev_rst   <= rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int target;
        rst = 1'b1;
        req = '0;
        bcd_in = '0;
        tx_if.tx_ready = 1'b1;
        tick();
        tick();
        chk("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_if.tx_data), 32'h00);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Single request, busy spans 4 send + 4 gap cycles.
        bcd_in[7:0] = 8'h47;
        req = 4'b0001;
        push_rec(0, 8'h34, 8'h37);
        target = done_cnt + 1;
        tick();
        req = '0;
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            tick();
        end
        chk("busy_cycles", 32'(cnt), 32'd8);
        chk("single_done", 32'(done_cnt >= target), 32'd1);

        // All four from reset: grant order 0,1,2,3,0,1,2,3.
        rst = 1'b1;
        tick();
        bcd_in = {8'h83, 8'h52, 8'h10, 8'h09};
        req = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            push_rec(0, 8'h30, 8'h39);
            push_rec(1, 8'h31, 8'h30);
            push_rec(2, 8'h35, 8'h32);
            push_rec(3, 8'h38, 8'h33);
        end
        target = done_cnt + 8;
        tick();
        rst = 1'b0;
        wait_done(target, 400);
        req = '0;
        tick();

        // Backpressure on requester 3.
        bp = 1'b1;
        send_one(3, 8'h58, 8'h35, 8'h38, 1'b0, 8'h00);
        bp = 1'b0;

        // Invalid BCD high digit.
        send_one(2, 8'hA9, 8'h3F, 8'h39, 1'b0, 8'h00);

        // Digits change after the grant; snapshot must win.
        send_one(1, 8'h12, 8'h31, 8'h32, 1'b1, 8'h99);

        // Reset after two bytes accepted.
        bcd_in[7:0] = 8'h47;
        req = 4'b0001;
        exp_q.push_back('{data: 8'h41, gnt: 4'b0001});
        exp_q.push_back('{data: 8'h34, gnt: 4'b0001});
        tick();
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_tx_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_queue", 32'(exp_q.size()), 32'd0);
        bcd_in[15:8] = 8'h12;
        req = 4'b0011;
        push_rec(0, 8'h34, 8'h37);
        push_rec(1, 8'h31, 8'h32);
        target = done_cnt + 2;
        tick();
        rst = 1'b0;
        wait_done(target, 400);
        req = '0;
        tick();

        chk("exp_bytes_left", 32'(exp_q.size()), 32'd0);
        chk("exp_done_left", 32'(exp_done.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_msg_sched.md
# uart_msg_sched

Round-robin scheduler that shares one byte-level UART serializer between N_REQ requesters, each reporting a two-digit BCD value. On grant it snapshots the requester's digits and emits a 4-byte ASCII record: channel tag, high digit, low digit, carriage return. Bytes go to the serializer over a valid/ready handshake. A programmable idle gap separates consecutive records on the line. The block sits between the measurement/display logic and the 19200 Bd transmit serializer.

## Interface
- N_REQ, 4, number of requesters; legal range 1..8.
- GAP_CYCLES, 834, idle clk cycles inserted after each record. 0 means no gap. Width of the gap counter is $clog2(GAP_CYCLES+1), minimum 1.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester; held high while the requester has a value to send.
- bcd_in  in  8*N_REQ  requester i uses two nibbles: [8i+7:8i+4] is the high digit, [8i+3:8i] is the low digit.
- gnt  out  N_REQ  one-hot; high for the granted requester from the first byte presented until the last byte is accepted.
- done  out  N_REQ  one-cycle pulse on requester i when its record has been fully accepted.
- tx_data  out  8  byte presented to the serializer.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  serializer accepts the byte; a transfer occurs when tx_valid && tx_ready.
- busy  out  1  high in SEND and GAP states.

## Operation
- States:
  - IDLE: no request being served.
  - SEND: presenting the bytes of a record.
  - GAP: counting out the inter-record gap.
- Reset state and outputs: state IDLE, rr pointer 0, byte index 0. gnt=0, done=0, tx_valid=0, tx_data=0x00, busy=0.
- Grant selection in IDLE, when any req bit is high:
  - Pick the first set req[i], searching i = ptr, ptr+1, … with wrap modulo N_REQ.
  - Latch bcd_in for requester i into an internal snapshot.
  - Set ptr to (i+1) mod N_REQ and go to SEND with byte index 0.
- Record bytes, in order:
  - idx 0: 0x41+i ('A'+i).
  - idx 1: high digit.
  - idx 2: low digit.
  - idx 3: 0x0D.
- Digit encoding: a nibble 0..9 is sent as {4'h3, nibble}. A nibble 10..15 is sent as 0x3F ('?').
- In SEND:
  - tx_valid stays high and tx_data stays stable until the byte is accepted.
  - On acceptance, idx increments and the next byte appears in the following cycle, with no bubble required.
  - When byte idx 3 is accepted:
    - tx_valid drops.
    - gnt clears.
    - done[i] pulses in the next cycle.
    - State goes to GAP with the counter loaded to GAP_CYCLES, or to IDLE if GAP_CYCLES=0.
- GAP: the counter decrements each cycle and returns to IDLE after GAP_CYCLES cycles. req is ignored during GAP.
- Snapshot semantics: changes on bcd_in or req[i] during SEND/GAP do not affect the record in flight. A record always completes once granted.
- A requester holding req high after done is eligible again, but only after all other pending requesters have been served once (round-robin fairness).
- Requesters with req=0 are skipped. With only one requester active, it is re-granted after every gap.
- Reset asserted mid-record aborts immediately: outputs return to reset values in the next cycle, no done is pulsed, and the partial record is not resumed.

## Timing
- Grant latency: req sampled high in IDLE at edge k gives tx_valid=1 with the tag byte after edge k (1 cycle).
- With tx_ready tied high, a record occupies exactly 4 cycles of tx_valid.
- The done pulse coincides with the first GAP cycle, or the first IDLE cycle when GAP_CYCLES=0.
- Cycles from the last acceptance to the next possible tx_valid: GAP_CYCLES+1.
- tx_valid never deasserts without a transfer except on rst.
- tx_data changes only when a transfer occurs or a new record begins.
- The serializer may hold tx_ready low for any duration; the block waits indefinitely with outputs stable.

## Test plan
- Single request, tx_ready=1, GAP_CYCLES=4, req[0]=1 with bcd_in[7:0]=0x47 held one cycle:
  - bytes 0x41,0x34,0x37,0x0D on 4 consecutive cycles.
  - done[0] pulses once.
  - busy stays high for 4+4 cycles.
- All four requesters high simultaneously from reset:
  - grant order 0,1,2,3,0…
  - tags 0x41,0x42,0x43,0x44 repeat.
  - each done pulses once per record.
- Backpressure: tx_ready toggles at random while a record is sent.
  - tx_data stays stable while tx_valid && !tx_ready.
  - the 4 bytes arrive in order with no loss and no duplication.
- Invalid BCD: requester 2 sends bcd_in=0xA9.
  - record is 0x43,0x3F,0x39,0x0D.
- Snapshot: bcd_in[15:8] changes from 0x12 to 0x99 after the grant to requester 1.
  - record still carries 0x31,0x32.
- Reset mid-record: rst asserted after 2 bytes are accepted.
  - next cycle: tx_valid=0, gnt=0, no done.
  - with req[0]=req[1]=1 after reset, requester 0 is granted first.
